rom_ddr_port: RTL

Responder end of the toggle-handshake ROM port. It serves 16-bit cartridge-ROM writes from the download path and 16-bit ROM reads from the console core. Each request becomes a single-beat access on the 64-bit DDR3 Avalon interface, and one 64-bit line is cached for reads. It sits between the top-level loader/core and the DDRAM_* pins.

---
 rtl/rom_ddr_port.sv | 117 +++++++++++
 1 files changed

// File: rtl/rom_ddr_port.sv
// rtl/rom_ddr_port.sv - toggle-handshake cartridge ROM port onto a 64-bit DDR3 Avalon master
// One cached 64-bit line serves reads; writes go straight to DDR and invalidate a matching line.
module rom_ddr_port #(
  parameter logic [28:0] ADDR_BASE = 29'h6000000
) (
  input  logic        clk_sys,
  input  logic        reset,

  input  logic [24:0] wraddr,
  input  logic [15:0] din,
  input  logic        we_req,
  output logic        we_ack,

  input  logic [23:0] rdaddr,
  output logic [15:0] dout,
  input  logic        rd_req,
  output logic        rd_ack,

  input  logic        DDRAM_BUSY,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic [28:0] DDRAM_ADDR,
  input  logic [63:0] DDRAM_DOUT,
  input  logic        DDRAM_DOUT_READY,
  output logic        DDRAM_RD,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE,
  output logic        DDRAM_WE
);

  typedef enum logic [2:0] {IDLE, WR, RD, RDWAIT, DRAIN} state_t;

  state_t      state, state_nx;
  logic [63:0] line;
  logic [21:0] tag;
  logic        valid;
  logic        we_pend, rd_pend, hit;
  logic        drain_on_reset;
  logic        unused_wraddr0;

  assign we_pend        = we_req != we_ack;
  assign rd_pend        = rd_req != rd_ack;
  assign hit            = valid && (tag == rdaddr[23:2]);
  assign DDRAM_BURSTCNT = 8'd1;
  assign unused_wraddr0 = wraddr[0];

  // A read beat already accepted by DDR must still be swallowed after reset.
  assign drain_on_reset = (state == RD && !DDRAM_BUSY) ||
                          ((state == RDWAIT || state == DRAIN) && !DDRAM_DOUT_READY);

  always_ff @(posedge clk_sys) begin
    if (reset) state <= drain_on_reset ? DRAIN : IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (we_pend) state_nx = WR;
               else if (rd_pend && !hit) state_nx = RD;
      WR:      if (!DDRAM_BUSY) state_nx = IDLE;
      RD:      if (!DDRAM_BUSY) state_nx = RDWAIT;
      RDWAIT:  if (DDRAM_DOUT_READY) state_nx = IDLE;
      DRAIN:   if (DDRAM_DOUT_READY) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      DDRAM_RD   <= 1'b0;
      DDRAM_WE   <= 1'b0;
      DDRAM_BE   <= 8'd0;
      DDRAM_DIN  <= 64'd0;
      DDRAM_ADDR <= ADDR_BASE;
      dout       <= 16'd0;
      we_ack     <= 1'b0;
      rd_ack     <= 1'b0;
      valid      <= 1'b0;
      line       <= 64'd0;
      tag        <= 22'd0;
    end else begin
      case (state)
        IDLE: begin
          if (we_pend) begin
            DDRAM_ADDR <= ADDR_BASE + {7'd0, wraddr[24:3]};
            DDRAM_DIN  <= {4{din}};
            DDRAM_BE   <= 8'b11 << {wraddr[2:1], 1'b0};
            DDRAM_WE   <= 1'b1;
            if (tag == wraddr[24:3]) valid <= 1'b0;
          end else if (rd_pend) begin
            if (hit) begin
              dout   <= line[{rdaddr[1:0], 4'd0} +: 16];
              rd_ack <= rd_req;
            end else begin
              DDRAM_ADDR <= ADDR_BASE + {7'd0, rdaddr[23:2]};
              DDRAM_RD   <= 1'b1;
            end
          end
        end
        WR: if (!DDRAM_BUSY) begin
          DDRAM_WE <= 1'b0;
          we_ack   <= we_req;
        end
        RD: if (!DDRAM_BUSY) DDRAM_RD <= 1'b0;
        RDWAIT: if (DDRAM_DOUT_READY) begin
          line   <= DDRAM_DOUT;
          tag    <= rdaddr[23:2];
          valid  <= 1'b1;
          dout   <= DDRAM_DOUT[{rdaddr[1:0], 4'd0} +: 16];
          rd_ack <= rd_req;
        end
        default: ;
      endcase
    end
  end

endmodule
